// File: rtl/lab4_calram_feed_if.sv
// rtl/lab4_calram_feed_if.sv - LAB4 sample streams in, calram write port and status out
interface lab4_calram_feed_if #(
  parameter int NUM_LABS  = 24,
  parameter int LAB4_BITS = 12
);
  logic                          arm_i;
  logic [NUM_LABS-1:0]           lab_en_i;
  logic [NUM_LABS*LAB4_BITS-1:0] in_dat_i;
  logic [NUM_LABS-1:0]           in_valid_i;
  logic [NUM_LABS-1:0]           in_sop_i;
  logic [NUM_LABS*LAB4_BITS-1:0] lab_dat_o;
  logic [NUM_LABS-1:0]           lab_wr_o;
  logic                          roll_o;
  logic [NUM_LABS-1:0]           err_o;
  logic                          busy_o;

  modport master (
    output arm_i, lab_en_i, in_dat_i, in_valid_i, in_sop_i,
    input  lab_dat_o, lab_wr_o, roll_o, err_o, busy_o
  );

  modport slave (
    input  arm_i, lab_en_i, in_dat_i, in_valid_i, in_sop_i,
    output lab_dat_o, lab_wr_o, roll_o, err_o, busy_o
  );
endinterface

// File: rtl/lab4_calram_feed.sv
// rtl/lab4_calram_feed.sv - gates LAB4 streams into aligned 4096-sample calram windows
module lab4_calram_feed #(
  parameter int NUM_LABS  = 24,
  parameter int LAB4_BITS = 12,
  parameter int WIN_BITS  = 12
) (
  input  logic sys_clk_i,
  input  logic rst_n_i,
  lab4_calram_feed_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_SOP, S_RUN, S_DONE, S_ERR} state_t;

  state_t                        r_state     [NUM_LABS];
  state_t                        w_state_nxt [NUM_LABS];
  logic [WIN_BITS-1:0]           r_cnt       [NUM_LABS];
  logic [WIN_BITS-1:0]           w_cnt_nxt   [NUM_LABS];
  logic [NUM_LABS-1:0]           r_mask, r_err, r_wr;
  logic [NUM_LABS*LAB4_BITS-1:0] r_dat;
  logic                          r_arm_q, r_roll, r_busy;
  logic [NUM_LABS-1:0]           w_fwd, w_err_set, w_done, w_fin, w_active;
  logic                          w_arm_edge, w_all_fin, w_any_done, w_roll, w_all_err;

  assign w_arm_edge = bus.arm_i & ~r_arm_q;

  always_comb begin
    w_done   = '0;
    w_fin    = '0;
    w_active = '0;
    for (int i = 0; i < NUM_LABS; i++) begin
      w_done[i]   = (r_state[i] == S_DONE);
      w_fin[i]    = (r_state[i] == S_DONE) || (r_state[i] == S_ERR);
      w_active[i] = (r_state[i] == S_WAIT_SOP) || (r_state[i] == S_RUN);
    end
  end

  // Unarmed LABs count as finished so they never hold off the roll.
  assign w_all_fin  = &(~r_mask | w_fin);
  assign w_any_done = |(r_mask & w_done);
  assign w_roll     = w_all_fin & w_any_done;
  assign w_all_err  = w_all_fin & ~w_any_done & (|r_mask);

  always_comb begin
    w_fwd     = '0;
    w_err_set = '0;
    for (int i = 0; i < NUM_LABS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        S_IDLE: begin
          if (w_arm_edge && bus.lab_en_i[i]) w_state_nxt[i] = S_WAIT_SOP;
        end
        S_WAIT_SOP: begin
          if (!bus.arm_i) begin
            w_state_nxt[i] = S_IDLE;
          end else if (bus.in_valid_i[i] && bus.in_sop_i[i]) begin
            w_fwd[i]       = 1'b1;
            w_cnt_nxt[i]   = WIN_BITS'(1);
            w_state_nxt[i] = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.in_valid_i[i]) begin
            if (bus.in_sop_i[i] && (r_cnt[i] != '0)) begin
              w_err_set[i]   = 1'b1;
              w_state_nxt[i] = S_ERR;
            end else begin
              w_fwd[i]     = 1'b1;
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
              if (r_cnt[i] == {WIN_BITS{1'b1}}) w_state_nxt[i] = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_roll) w_state_nxt[i] = bus.arm_i ? S_WAIT_SOP : S_IDLE;
        end
        S_ERR: begin
          if (w_arm_edge)     w_state_nxt[i] = bus.lab_en_i[i] ? S_WAIT_SOP : S_IDLE;
          else if (w_all_err) w_state_nxt[i] = S_IDLE;
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  // arm_q resets high so an arm_i already high at reset release is not an edge.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_LABS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
      r_mask  <= '0;
      r_err   <= '0;
      r_wr    <= '0;
      r_dat   <= '0;
      r_roll  <= 1'b0;
      r_busy  <= 1'b0;
      r_arm_q <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_LABS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        if (w_fwd[i]) r_dat[i*LAB4_BITS +: LAB4_BITS] <= bus.in_dat_i[i*LAB4_BITS +: LAB4_BITS];
      end
      r_arm_q <= bus.arm_i;
      if (w_arm_edge) r_mask <= bus.lab_en_i;
      r_err  <= (w_arm_edge ? '0 : r_err) | w_err_set;
      r_wr   <= w_fwd;
      r_roll <= w_roll;
      r_busy <= |(r_mask & w_active);
    end
  end

  assign bus.lab_dat_o = r_dat;
  assign bus.lab_wr_o  = r_wr;
  assign bus.roll_o    = r_roll;
  assign bus.err_o     = r_err;
  assign bus.busy_o    = r_busy;
endmodule
